pong_vga_renderer: RTL and testbench

Display stage directly downstream of the pong game-state block: it consumes ball and paddle positions in game cell units and renders them as a 640×480@60 Hz VGA image. The 2-bit-per-channel RGB and sync outputs are formatted for the TinyVGA PMOD on `uo_out`. It also emits `frame_tick`, a once-per-frame strobe that the game-state block uses as its update enable. Positions are snapshotted once per frame so an image never tears mid-frame.

---
 rtl/pong_pkg.sv | 47 ++++
 rtl/pong_vga_renderer_sync.sv | 33 +++
 rtl/pong_vga_renderer.sv | 115 +++++++++++
 tb/tb_pong_vga_renderer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong display path.
// VGA 640x480@60 timing, playfield geometry, colours, distance helper.
package pong_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = 10'd800;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam int CELL_SHIFT    = 2;
    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int PADDLE_EXTENT = 4;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t WHITE = rgb_t'(6'b11_11_11);
    localparam rgb_t GREY  = rgb_t'(6'b01_01_01);
    localparam rgb_t BLACK = rgb_t'(6'b00_00_00);

    // 9-bit difference so 0 vs 255 is a distance of 255, never 1.
    function automatic logic [8:0] abs_diff(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[8] ? (~d + 9'd1) : d;
    endfunction

endpackage

// File: rtl/pong_vga_renderer_sync.sv
// VGA timing generator: h/v counters, raw (unregistered) sync,
// active-area flag and vertical-blank-start pulse for the renderer.
module vga_sync_gen
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       active,
    output logic       vblank_start
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_TOTAL - 10'd1) begin
            h <= '0;
            v <= (v == V_TOTAL - 10'd1) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign hsync_raw    = !(h >= H_SYNC_START && h < H_SYNC_END);
    assign vsync_raw    = !(v >= V_SYNC_START && v < V_SYNC_END);
    assign active       = (h < H_ACTIVE) && (v < V_ACTIVE);
    assign vblank_start = (h == 10'd0) && (v == V_ACTIVE);

endmodule

// File: rtl/pong_vga_renderer.sv
// Renders ball, paddles and net from per-frame position snapshots.
// Ports: clk, rst_n, positions in -> hsync/vsync/rgb/frame_tick/display_en, uo_out (TinyVGA).
module pong_vga_renderer #(
    parameter int CELL_SHIFT    = pong_pkg::CELL_SHIFT,
    parameter int SCREEN_W      = pong_pkg::SCREEN_W,
    parameter int SCREEN_H      = pong_pkg::SCREEN_H,
    parameter int PADDLE_EXTENT = pong_pkg::PADDLE_EXTENT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ball_x,
    input  logic [7:0] ball_y,
    input  logic [7:0] left_paddle_y,
    input  logic [7:0] right_paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] red,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       frame_tick,
    output logic       display_en,
    output logic [7:0] uo_out
);
    import pong_pkg::*;

    logic [9:0] h;
    logic [9:0] v;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       active;
    logic       vblank_start;

    vga_sync_gen u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .h            (h),
        .v            (v),
        .hsync_raw    (hsync_raw),
        .vsync_raw    (vsync_raw),
        .active       (active),
        .vblank_start (vblank_start)
    );

    logic [7:0] shadow_ball_x;
    logic [7:0] shadow_ball_y;
    logic [7:0] shadow_left_y;
    logic [7:0] shadow_right_y;

    logic [9:0] cx;
    logic [9:0] cy;
    logic       ball_hit;
    logic       left_hit;
    logic       right_hit;
    logic       net_hit;
    rgb_t       pix;
    rgb_t       rgb;

    assign cx = h >> CELL_SHIFT;
    assign cy = v >> CELL_SHIFT;

    // Off-screen ball coordinates must never alias into the blanking
    // region's cell numbers, so range-check against the playfield.
    assign ball_hit = (cx == {2'b0, shadow_ball_x})
                   && (cy == {2'b0, shadow_ball_y})
                   && ({2'b0, shadow_ball_x} < 10'(SCREEN_W))
                   && ({2'b0, shadow_ball_y} < 10'(SCREEN_H));

    assign left_hit  = (cx == 10'd0)
                    && (abs_diff(cy[7:0], shadow_left_y) <= 9'(PADDLE_EXTENT));
    assign right_hit = (cx == 10'(SCREEN_W - 1))
                    && (abs_diff(cy[7:0], shadow_right_y) <= 9'(PADDLE_EXTENT));
    assign net_hit   = (cx == 10'(SCREEN_W / 2)) && !cy[2];

    always_comb begin
        pix = BLACK;
        if (ball_hit)       pix = WHITE;
        else if (left_hit)  pix = WHITE;
        else if (right_hit) pix = WHITE;
        else if (net_hit)   pix = GREY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync          <= 1'b1;
            vsync          <= 1'b1;
            rgb            <= BLACK;
            frame_tick     <= 1'b0;
            display_en     <= 1'b0;
            shadow_ball_x  <= '0;
            shadow_ball_y  <= '0;
            shadow_left_y  <= '0;
            shadow_right_y <= '0;
        end else begin
            hsync      <= hsync_raw;
            vsync      <= vsync_raw;
            display_en <= active;
            frame_tick <= vblank_start;
            rgb        <= active ? pix : BLACK;
            if (vblank_start) begin
                shadow_ball_x  <= ball_x;
                shadow_ball_y  <= ball_y;
                shadow_left_y  <= left_paddle_y;
                shadow_right_y <= right_paddle_y;
            end
        end
    end

    assign red   = rgb.r;
    assign green = rgb.g;
    assign blue  = rgb.b;

    assign uo_out = {hsync, blue[0], green[0], red[0],
                     vsync, blue[1], green[1], red[1]};

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Directed bench for pong_vga_renderer.
// Counter jumps skip the long blanking stretches between frames.
module tb_pong_vga_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ball_x = 8'd0;
    logic [7:0] ball_y = 8'd0;
    logic [7:0] left_paddle_y = 8'd0;
    logic [7:0] right_paddle_y = 8'd0;
    logic       hsync;
    logic       vsync;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic       frame_tick;
    logic       display_en;
    logic [7:0] uo_out;

    localparam logic [5:0] C_WHITE = 6'h3F;
    localparam logic [5:0] C_GREY  = 6'h15;
    localparam logic [5:0] C_BLACK = 6'h00;

    int nvec = 0;
    int nmis = 0;

    logic [9:0] fh;
    logic [9:0] fv;

    pong_vga_renderer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .left_paddle_y  (left_paddle_y),
        .right_paddle_y (right_paddle_y),
        .hsync          (hsync),
        .vsync          (vsync),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .frame_tick     (frame_tick),
        .display_en     (display_en),
        .uo_out         (uo_out)
    );

    always #20 clk = ~clk;

    wire [5:0] rgb = {red, green, blue};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counter lands on (hh,vv); the next posedge registers that pixel.
    task set_cnt(input logic [9:0] hh, input logic [9:0] vv);
        @(negedge clk);
        fh = hh;
        fv = vv;
        force dut.u_sync.h = fh;
        force dut.u_sync.v = fv;
        #1;
        release dut.u_sync.h;
        release dut.u_sync.v;
    endtask

    task pix(input logic [9:0] hh, input logic [9:0] vv,
             input logic [5:0] exp, input string tag);
        set_cnt(hh, vv);
        @(negedge clk);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        int fall1, fall2, low_n, first_low, tick_n, tick_at;
        logic prev;

        repeat (3) @(negedge clk);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_de", 32'(display_en), 32'd0);
        chk("rst_uo", 32'(uo_out), 32'h88);

        // Free run from reset: shadows are zero, so ball and both
        // paddles sit on row 0.
        rst_n = 1'b1;
        fall1 = -1; fall2 = -1; low_n = 0; prev = 1'b1;
        for (int i = 1; i <= 1500; i++) begin
            @(negedge clk);
            if (i == 1)   chk("first_px", 32'(rgb), 32'(C_WHITE));
            if (i == 1)   chk("first_uo", 32'(uo_out), 32'hFF);
            if (i == 321) chk("net_row0", 32'(rgb), 32'(C_GREY));
            if (i == 637) chk("rpad_row0", 32'(rgb), 32'(C_WHITE));
            if (i == 640) chk("de_last", 32'(display_en), 32'd1);
            if (i == 641) chk("de_off", 32'(display_en), 32'd0);
            if (prev && !hsync) begin
                if (fall1 < 0) fall1 = i;
                else if (fall2 < 0) fall2 = i;
            end
            if (!hsync && fall2 < 0) low_n++;
            prev = hsync;
        end
        chk("hs_first", 32'(fall1), 32'd657);
        chk("hs_low", 32'(low_n), 32'd96);
        chk("hs_period", 32'(fall2 - fall1), 32'd800);

        set_cnt(10'd799, 10'd489);
        first_low = -1; low_n = 0;
        for (int j = 0; j <= 1700; j++) begin
            @(negedge clk);
            if (!vsync) begin
                low_n++;
                if (first_low < 0) first_low = j;
            end
        end
        chk("vs_first", 32'(first_low), 32'd1);
        chk("vs_low", 32'(low_n), 32'd1600);

        ball_x = 8'd10; ball_y = 8'd20;
        left_paddle_y = 8'd0; right_paddle_y = 8'd60;
        set_cnt(10'd795, 10'd479);
        tick_n = 0; tick_at = -1;
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            if (frame_tick) begin
                tick_n++;
                if (tick_at < 0) tick_at = j;
            end
        end
        chk("tick_at", 32'(tick_at), 32'd5);
        chk("tick_cnt", 32'(tick_n), 32'd1);

        pix(10'd40, 10'd80, C_WHITE, "ball_tl");
        pix(10'd43, 10'd83, C_WHITE, "ball_br");
        pix(10'd39, 10'd80, C_BLACK, "ball_left");
        pix(10'd44, 10'd80, C_BLACK, "ball_right");
        pix(10'd41, 10'd84, C_BLACK, "ball_below");
        pix(10'd2, 10'd10, C_WHITE, "lpad_mid");
        pix(10'd0, 10'd19, C_WHITE, "lpad_edge");
        pix(10'd0, 10'd20, C_BLACK, "lpad_out");
        pix(10'd0, 10'd460, C_BLACK, "lpad_nowrap");
        pix(10'd3, 10'd476, C_BLACK, "lpad_bottom");
        pix(10'd636, 10'd224, C_WHITE, "rpad_top");
        pix(10'd639, 10'd259, C_WHITE, "rpad_bot");
        pix(10'd636, 10'd220, C_BLACK, "rpad_above");
        pix(10'd636, 10'd260, C_BLACK, "rpad_below");
        pix(10'd320, 10'd0, C_GREY, "net_on");
        pix(10'd320, 10'd16, C_BLACK, "net_gap");
        pix(10'd321, 10'd32, C_GREY, "net_on2");
        pix(10'd650, 10'd100, C_BLACK, "hblank");
        chk("hblank_de", 32'(display_en), 32'd0);

        // Mid-frame input change stays hidden until the next snapshot.
        ball_x = 8'd50;
        left_paddle_y = 8'd255;
        pix(10'd40, 10'd100, C_BLACK, "old_row");
        pix(10'd40, 10'd80, C_WHITE, "old_ball");
        pix(10'd200, 10'd80, C_BLACK, "new_early");
        pix(10'd0, 10'd480, C_BLACK, "snap_blank");
        chk("snap_de", 32'(display_en), 32'd0);
        chk("snap_tick", 32'(frame_tick), 32'd1);
        pix(10'd200, 10'd80, C_WHITE, "new_ball");
        pix(10'd40, 10'd80, C_BLACK, "old_gone");
        pix(10'd0, 10'd0, C_BLACK, "lpad_255_r0");
        pix(10'd0, 10'd4, C_BLACK, "lpad_255_r1");

        ball_x = 8'd80; ball_y = 8'd0;
        pix(10'd0, 10'd480, C_BLACK, "snap2");
        pix(10'd320, 10'd0, C_WHITE, "ball_on_net");
        pix(10'd320, 10'd4, C_GREY, "net_below");

        ball_x = 8'd200; ball_y = 8'd20;
        pix(10'd0, 10'd480, C_BLACK, "snap3");
        pix(10'd200, 10'd80, C_BLACK, "x200_a");
        pix(10'd40, 10'd80, C_BLACK, "x200_b");
        pix(10'd320, 10'd0, C_GREY, "x200_net");

        // Asynchronous reset mid-frame.
        set_cnt(10'd300, 10'd200);
        @(negedge clk);
        chk("pre_rst_de", 32'(display_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_hsync", 32'(hsync), 32'd1);
        chk("mr_vsync", 32'(vsync), 32'd1);
        chk("mr_rgb", 32'(rgb), 32'd0);
        chk("mr_tick", 32'(frame_tick), 32'd0);
        chk("mr_de", 32'(display_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fall1 = -1; prev = 1'b1;
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            if (i == 1)   chk("rr_px0", 32'(rgb), 32'(C_WHITE));
            if (i == 321) chk("rr_net", 32'(rgb), 32'(C_GREY));
            if (prev && !hsync && fall1 < 0) fall1 = i;
            prev = hsync;
        end
        chk("rr_hs", 32'(fall1), 32'd657);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
